// File: rtl/axi4_id_throttle.sv
// ---------------------------------------------------------------------------
// axi4_id_throttle
//
// Per-ID outstanding-transaction limiter and quiesce controller that sits
// between an AXI4 master and the ID fabric. Every payload passes straight
// through with zero latency. Only AW and AR valid/ready are gated.
//
// Two counters track each ID:
//   - wcnt counts open writes: AW accepted, B not yet returned.
//   - rcnt counts open reads: AR accepted, last R not yet returned.
//
// A new AW/AR is held off in either of these cases:
//   - its ID already has MAX_OUTSTANDING transactions open.
//   - drain_req is high.
//
// Ports:
//   clock, reset            sole clock; synchronous active-high reset
//   auto_in_aw_* / auto_out_aw_*   write-address channel, gated per ID
//   auto_in_ar_* / auto_out_ar_*   read-address channel, gated per ID
//   auto_in_w_*  / auto_out_w_*    write data, pure passthrough
//   auto_out_b_* / auto_in_b_*     write response, passthrough + monitored
//   auto_out_r_* / auto_in_r_*     read data, passthrough + monitored
//   drain_req               stop admitting new AW/AR while high
//   idle                    every counter is zero
//   underflow               sticky: response seen for an ID with no open txn
// ---------------------------------------------------------------------------
module axi4_id_throttle #(
  parameter  int ID_BITS         = 4,
  parameter  int MAX_OUTSTANDING = 4,
  localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic               clock,
  input  logic               reset,

  input  logic               auto_in_aw_valid,
  output logic               auto_in_aw_ready,
  input  logic [ID_BITS-1:0] auto_in_aw_bits_id,
  input  logic [31:0]        auto_in_aw_bits_addr,
  input  logic [7:0]         auto_in_aw_bits_len,
  input  logic [2:0]         auto_in_aw_bits_size,
  input  logic [1:0]         auto_in_aw_bits_burst,
  input  logic               auto_in_aw_bits_lock,
  input  logic [3:0]         auto_in_aw_bits_cache,
  input  logic [2:0]         auto_in_aw_bits_prot,
  input  logic [3:0]         auto_in_aw_bits_qos,
  input  logic [3:0]         auto_in_aw_bits_echo_tl_state_size,
  input  logic [3:0]         auto_in_aw_bits_echo_tl_state_source,
  output logic               auto_out_aw_valid,
  input  logic               auto_out_aw_ready,
  output logic [ID_BITS-1:0] auto_out_aw_bits_id,
  output logic [31:0]        auto_out_aw_bits_addr,
  output logic [7:0]         auto_out_aw_bits_len,
  output logic [2:0]         auto_out_aw_bits_size,
  output logic [1:0]         auto_out_aw_bits_burst,
  output logic               auto_out_aw_bits_lock,
  output logic [3:0]         auto_out_aw_bits_cache,
  output logic [2:0]         auto_out_aw_bits_prot,
  output logic [3:0]         auto_out_aw_bits_qos,
  output logic [3:0]         auto_out_aw_bits_echo_tl_state_size,
  output logic [3:0]         auto_out_aw_bits_echo_tl_state_source,

  input  logic               auto_in_ar_valid,
  output logic               auto_in_ar_ready,
  input  logic [ID_BITS-1:0] auto_in_ar_bits_id,
  input  logic [31:0]        auto_in_ar_bits_addr,
  input  logic [7:0]         auto_in_ar_bits_len,
  input  logic [2:0]         auto_in_ar_bits_size,
  input  logic [1:0]         auto_in_ar_bits_burst,
  input  logic               auto_in_ar_bits_lock,
  input  logic [3:0]         auto_in_ar_bits_cache,
  input  logic [2:0]         auto_in_ar_bits_prot,
  input  logic [3:0]         auto_in_ar_bits_qos,
  input  logic [3:0]         auto_in_ar_bits_echo_tl_state_size,
  input  logic [3:0]         auto_in_ar_bits_echo_tl_state_source,
  output logic               auto_out_ar_valid,
  input  logic               auto_out_ar_ready,
  output logic [ID_BITS-1:0] auto_out_ar_bits_id,
  output logic [31:0]        auto_out_ar_bits_addr,
  output logic [7:0]         auto_out_ar_bits_len,
  output logic [2:0]         auto_out_ar_bits_size,
  output logic [1:0]         auto_out_ar_bits_burst,
  output logic               auto_out_ar_bits_lock,
  output logic [3:0]         auto_out_ar_bits_cache,
  output logic [2:0]         auto_out_ar_bits_prot,
  output logic [3:0]         auto_out_ar_bits_qos,
  output logic [3:0]         auto_out_ar_bits_echo_tl_state_size,
  output logic [3:0]         auto_out_ar_bits_echo_tl_state_source,

  input  logic               auto_in_w_valid,
  output logic               auto_in_w_ready,
  input  logic [63:0]        auto_in_w_bits_data,
  input  logic [7:0]         auto_in_w_bits_strb,
  input  logic               auto_in_w_bits_last,
  output logic               auto_out_w_valid,
  input  logic               auto_out_w_ready,
  output logic [63:0]        auto_out_w_bits_data,
  output logic [7:0]         auto_out_w_bits_strb,
  output logic               auto_out_w_bits_last,

  input  logic               auto_out_b_valid,
  output logic               auto_out_b_ready,
  input  logic [ID_BITS-1:0] auto_out_b_bits_id,
  input  logic [1:0]         auto_out_b_bits_resp,
  input  logic [3:0]         auto_out_b_bits_echo_tl_state_size,
  input  logic [3:0]         auto_out_b_bits_echo_tl_state_source,
  output logic               auto_in_b_valid,
  input  logic               auto_in_b_ready,
  output logic [ID_BITS-1:0] auto_in_b_bits_id,
  output logic [1:0]         auto_in_b_bits_resp,
  output logic [3:0]         auto_in_b_bits_echo_tl_state_size,
  output logic [3:0]         auto_in_b_bits_echo_tl_state_source,

  input  logic               auto_out_r_valid,
  output logic               auto_out_r_ready,
  input  logic [ID_BITS-1:0] auto_out_r_bits_id,
  input  logic [63:0]        auto_out_r_bits_data,
  input  logic [1:0]         auto_out_r_bits_resp,
  input  logic [3:0]         auto_out_r_bits_echo_tl_state_size,
  input  logic [3:0]         auto_out_r_bits_echo_tl_state_source,
  input  logic               auto_out_r_bits_last,
  output logic               auto_in_r_valid,
  input  logic               auto_in_r_ready,
  output logic [ID_BITS-1:0] auto_in_r_bits_id,
  output logic [63:0]        auto_in_r_bits_data,
  output logic [1:0]         auto_in_r_bits_resp,
  output logic [3:0]         auto_in_r_bits_echo_tl_state_size,
  output logic [3:0]         auto_in_r_bits_echo_tl_state_source,
  output logic               auto_in_r_bits_last,

  input  logic               drain_req,
  output logic               idle,
  output logic               underflow
);

  localparam int               NUM_IDS = 1 << ID_BITS;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  logic [CNT_W-1:0]   wcnt [NUM_IDS];
  logic [CNT_W-1:0]   rcnt [NUM_IDS];
  logic               aw_block, ar_block;
  logic               aw_fire, ar_fire, b_fire, r_last_fire;
  logic [NUM_IDS-1:0] w_inc, w_dec, r_inc, r_dec;
  logic               under_hit;

  // Admission gating. The decision uses only registered counts, drain_req
  // and the request's own ID. A downstream ready therefore never feeds back
  // into its own valid. A response retiring this cycle only unblocks the
  // next cycle.
  assign aw_block = drain_req | (wcnt[auto_in_aw_bits_id] == CNT_MAX);
  assign ar_block = drain_req | (rcnt[auto_in_ar_bits_id] == CNT_MAX);

  assign auto_out_aw_valid = auto_in_aw_valid  & ~aw_block;
  assign auto_in_aw_ready  = auto_out_aw_ready & ~aw_block;
  assign auto_out_ar_valid = auto_in_ar_valid  & ~ar_block;
  assign auto_in_ar_ready  = auto_out_ar_ready & ~ar_block;

  assign aw_fire     = auto_out_aw_valid & auto_out_aw_ready;
  assign ar_fire     = auto_out_ar_valid & auto_out_ar_ready;
  assign b_fire      = auto_out_b_valid & auto_in_b_ready;
  assign r_last_fire = auto_out_r_valid & auto_in_r_ready & auto_out_r_bits_last;

  // Address payloads are straight copies; only valid/ready are touched above.
  assign auto_out_aw_bits_id                   = auto_in_aw_bits_id;
  assign auto_out_aw_bits_addr                 = auto_in_aw_bits_addr;
  assign auto_out_aw_bits_len                  = auto_in_aw_bits_len;
  assign auto_out_aw_bits_size                 = auto_in_aw_bits_size;
  assign auto_out_aw_bits_burst                = auto_in_aw_bits_burst;
  assign auto_out_aw_bits_lock                 = auto_in_aw_bits_lock;
  assign auto_out_aw_bits_cache                = auto_in_aw_bits_cache;
  assign auto_out_aw_bits_prot                 = auto_in_aw_bits_prot;
  assign auto_out_aw_bits_qos                  = auto_in_aw_bits_qos;
  assign auto_out_aw_bits_echo_tl_state_size   = auto_in_aw_bits_echo_tl_state_size;
  assign auto_out_aw_bits_echo_tl_state_source = auto_in_aw_bits_echo_tl_state_source;

  assign auto_out_ar_bits_id                   = auto_in_ar_bits_id;
  assign auto_out_ar_bits_addr                 = auto_in_ar_bits_addr;
  assign auto_out_ar_bits_len                  = auto_in_ar_bits_len;
  assign auto_out_ar_bits_size                 = auto_in_ar_bits_size;
  assign auto_out_ar_bits_burst                = auto_in_ar_bits_burst;
  assign auto_out_ar_bits_lock                 = auto_in_ar_bits_lock;
  assign auto_out_ar_bits_cache                = auto_in_ar_bits_cache;
  assign auto_out_ar_bits_prot                 = auto_in_ar_bits_prot;
  assign auto_out_ar_bits_qos                  = auto_in_ar_bits_qos;
  assign auto_out_ar_bits_echo_tl_state_size   = auto_in_ar_bits_echo_tl_state_size;
  assign auto_out_ar_bits_echo_tl_state_source = auto_in_ar_bits_echo_tl_state_source;

  // W is never gated. AXI allows write data ahead of its address, and the
  // slave owns that ordering, so holding W here could deadlock the fabric.
  assign auto_out_w_valid     = auto_in_w_valid;
  assign auto_in_w_ready      = auto_out_w_ready;
  assign auto_out_w_bits_data = auto_in_w_bits_data;
  assign auto_out_w_bits_strb = auto_in_w_bits_strb;
  assign auto_out_w_bits_last = auto_in_w_bits_last;

  assign auto_in_b_valid                     = auto_out_b_valid;
  assign auto_out_b_ready                    = auto_in_b_ready;
  assign auto_in_b_bits_id                   = auto_out_b_bits_id;
  assign auto_in_b_bits_resp                 = auto_out_b_bits_resp;
  assign auto_in_b_bits_echo_tl_state_size   = auto_out_b_bits_echo_tl_state_size;
  assign auto_in_b_bits_echo_tl_state_source = auto_out_b_bits_echo_tl_state_source;

  assign auto_in_r_valid                     = auto_out_r_valid;
  assign auto_out_r_ready                    = auto_in_r_ready;
  assign auto_in_r_bits_id                   = auto_out_r_bits_id;
  assign auto_in_r_bits_data                 = auto_out_r_bits_data;
  assign auto_in_r_bits_resp                 = auto_out_r_bits_resp;
  assign auto_in_r_bits_echo_tl_state_size   = auto_out_r_bits_echo_tl_state_size;
  assign auto_in_r_bits_echo_tl_state_source = auto_out_r_bits_echo_tl_state_source;
  assign auto_in_r_bits_last                 = auto_out_r_bits_last;

  // Per-ID increment/decrement strobes. An underflow is a decrement on a
  // zero counter with no increment on the same ID in the same cycle. When
  // an increment and a decrement land on one ID together, they cancel out.
  always_comb begin
    w_inc     = '0;
    w_dec     = '0;
    r_inc     = '0;
    r_dec     = '0;
    under_hit = 1'b0;
    for (int i = 0; i < NUM_IDS; i++) begin
      w_inc[i] = aw_fire     & (auto_in_aw_bits_id  == ID_BITS'(i));
      w_dec[i] = b_fire      & (auto_out_b_bits_id  == ID_BITS'(i));
      r_inc[i] = ar_fire     & (auto_in_ar_bits_id  == ID_BITS'(i));
      r_dec[i] = r_last_fire & (auto_out_r_bits_id  == ID_BITS'(i));
      if (w_dec[i] && !w_inc[i] && (wcnt[i] == '0)) under_hit = 1'b1;
      if (r_dec[i] && !r_inc[i] && (rcnt[i] == '0)) under_hit = 1'b1;
    end
  end

  // Counter state.
  //   - Increments saturate at the limit instead of wrapping.
  //   - Decrements stop at zero; the underflow flag records the bad response.
  //   - Reset clears everything, even with transactions still open downstream.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_IDS; i++) begin
        wcnt[i] <= '0;
        rcnt[i] <= '0;
      end
      underflow <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_IDS; i++) begin
        if (w_inc[i] && !w_dec[i] && (wcnt[i] != CNT_MAX))
          wcnt[i] <= wcnt[i] + 1'b1;
        else if (w_dec[i] && !w_inc[i] && (wcnt[i] != '0))
          wcnt[i] <= wcnt[i] - 1'b1;
        if (r_inc[i] && !r_dec[i] && (rcnt[i] != CNT_MAX))
          rcnt[i] <= rcnt[i] + 1'b1;
        else if (r_dec[i] && !r_inc[i] && (rcnt[i] != '0))
          rcnt[i] <= rcnt[i] - 1'b1;
      end
      if (under_hit) underflow <= 1'b1;
    end
  end

  // idle comes from registered counts only. It therefore trails the last
  // retiring response by exactly one cycle.
  always_comb begin
    idle = 1'b1;
    for (int i = 0; i < NUM_IDS; i++) begin
      if ((wcnt[i] != '0) || (rcnt[i] != '0)) idle = 1'b0;
    end
  end

endmodule

// File: tb/tb_axi4_id_throttle.sv
// ---------------------------------------------------------------------------
// tb_axi4_id_throttle
//
// Directed checks for axi4_id_throttle at ID_BITS=4, MAX_OUTSTANDING=4.
//   - A vector table covers:
//       - per-ID AW/AR limiting
//       - response retirement
//       - same-cycle increment/decrement
//       - idle timing
//   - Hand-written sequences cover:
//       - drain
//       - underflow
//       - reset with transactions open
// ---------------------------------------------------------------------------
module tb_axi4_id_throttle;

  localparam int ID_BITS = 4;
  localparam int MAXO    = 4;

  logic clock = 1'b0;
  logic reset;

  logic               in_aw_valid, in_aw_ready, out_aw_valid, out_aw_ready;
  logic [ID_BITS-1:0] in_aw_id, out_aw_id;
  logic [31:0]        in_aw_addr, out_aw_addr;
  logic [7:0]         out_aw_len;
  logic [2:0]         out_aw_size, out_aw_prot;
  logic [1:0]         out_aw_burst;
  logic               out_aw_lock;
  logic [3:0]         out_aw_cache, out_aw_qos, out_aw_esz, out_aw_esrc;

  logic               in_ar_valid, in_ar_ready, out_ar_valid, out_ar_ready;
  logic [ID_BITS-1:0] in_ar_id, out_ar_id;
  logic [31:0]        in_ar_addr, out_ar_addr;
  logic [7:0]         in_ar_len, out_ar_len;
  logic [2:0]         out_ar_size, out_ar_prot;
  logic [1:0]         out_ar_burst;
  logic               out_ar_lock;
  logic [3:0]         out_ar_cache, out_ar_qos, out_ar_esz, out_ar_esrc;

  logic        in_w_valid, in_w_ready, out_w_valid, out_w_ready;
  logic [63:0] in_w_data, out_w_data;
  logic [7:0]  out_w_strb;
  logic        out_w_last;

  logic               b_valid_dn, b_ready_dn, b_valid_up, b_ready_up;
  logic [ID_BITS-1:0] b_id_dn, b_id_up;
  logic [1:0]         b_resp_dn, b_resp_up;
  logic [3:0]         b_esz_up, b_esrc_up;

  logic               r_valid_dn, r_ready_dn, r_valid_up, r_ready_up;
  logic [ID_BITS-1:0] r_id_dn, r_id_up;
  logic [63:0]        r_data_dn, r_data_up;
  logic [1:0]         r_resp_up;
  logic [3:0]         r_esz_up, r_esrc_up;
  logic               r_last_dn, r_last_up;

  logic drain_req, idle, underflow;

  int checks = 0;
  int errors = 0;

  axi4_id_throttle #(.ID_BITS(ID_BITS), .MAX_OUTSTANDING(MAXO)) dut (
    .clock(clock), .reset(reset),
    .auto_in_aw_valid(in_aw_valid), .auto_in_aw_ready(in_aw_ready),
    .auto_in_aw_bits_id(in_aw_id), .auto_in_aw_bits_addr(in_aw_addr),
    .auto_in_aw_bits_len(8'd0), .auto_in_aw_bits_size(3'd3),
    .auto_in_aw_bits_burst(2'd1), .auto_in_aw_bits_lock(1'b0),
    .auto_in_aw_bits_cache(4'd0), .auto_in_aw_bits_prot(3'd0),
    .auto_in_aw_bits_qos(4'd0), .auto_in_aw_bits_echo_tl_state_size(4'd3),
    .auto_in_aw_bits_echo_tl_state_source(4'd1),
    .auto_out_aw_valid(out_aw_valid), .auto_out_aw_ready(out_aw_ready),
    .auto_out_aw_bits_id(out_aw_id), .auto_out_aw_bits_addr(out_aw_addr),
    .auto_out_aw_bits_len(out_aw_len), .auto_out_aw_bits_size(out_aw_size),
    .auto_out_aw_bits_burst(out_aw_burst), .auto_out_aw_bits_lock(out_aw_lock),
    .auto_out_aw_bits_cache(out_aw_cache), .auto_out_aw_bits_prot(out_aw_prot),
    .auto_out_aw_bits_qos(out_aw_qos), .auto_out_aw_bits_echo_tl_state_size(out_aw_esz),
    .auto_out_aw_bits_echo_tl_state_source(out_aw_esrc),
    .auto_in_ar_valid(in_ar_valid), .auto_in_ar_ready(in_ar_ready),
    .auto_in_ar_bits_id(in_ar_id), .auto_in_ar_bits_addr(in_ar_addr),
    .auto_in_ar_bits_len(in_ar_len), .auto_in_ar_bits_size(3'd3),
    .auto_in_ar_bits_burst(2'd1), .auto_in_ar_bits_lock(1'b0),
    .auto_in_ar_bits_cache(4'd0), .auto_in_ar_bits_prot(3'd0),
    .auto_in_ar_bits_qos(4'd0), .auto_in_ar_bits_echo_tl_state_size(4'd3),
    .auto_in_ar_bits_echo_tl_state_source(4'd2),
    .auto_out_ar_valid(out_ar_valid), .auto_out_ar_ready(out_ar_ready),
    .auto_out_ar_bits_id(out_ar_id), .auto_out_ar_bits_addr(out_ar_addr),
    .auto_out_ar_bits_len(out_ar_len), .auto_out_ar_bits_size(out_ar_size),
    .auto_out_ar_bits_burst(out_ar_burst), .auto_out_ar_bits_lock(out_ar_lock),
    .auto_out_ar_bits_cache(out_ar_cache), .auto_out_ar_bits_prot(out_ar_prot),
    .auto_out_ar_bits_qos(out_ar_qos), .auto_out_ar_bits_echo_tl_state_size(out_ar_esz),
    .auto_out_ar_bits_echo_tl_state_source(out_ar_esrc),
    .auto_in_w_valid(in_w_valid), .auto_in_w_ready(in_w_ready),
    .auto_in_w_bits_data(in_w_data), .auto_in_w_bits_strb(8'hff),
    .auto_in_w_bits_last(1'b1),
    .auto_out_w_valid(out_w_valid), .auto_out_w_ready(out_w_ready),
    .auto_out_w_bits_data(out_w_data), .auto_out_w_bits_strb(out_w_strb),
    .auto_out_w_bits_last(out_w_last),
    .auto_out_b_valid(b_valid_dn), .auto_out_b_ready(b_ready_dn),
    .auto_out_b_bits_id(b_id_dn), .auto_out_b_bits_resp(b_resp_dn),
    .auto_out_b_bits_echo_tl_state_size(4'd3),
    .auto_out_b_bits_echo_tl_state_source(4'd5),
    .auto_in_b_valid(b_valid_up), .auto_in_b_ready(b_ready_up),
    .auto_in_b_bits_id(b_id_up), .auto_in_b_bits_resp(b_resp_up),
    .auto_in_b_bits_echo_tl_state_size(b_esz_up),
    .auto_in_b_bits_echo_tl_state_source(b_esrc_up),
    .auto_out_r_valid(r_valid_dn), .auto_out_r_ready(r_ready_dn),
    .auto_out_r_bits_id(r_id_dn), .auto_out_r_bits_data(r_data_dn),
    .auto_out_r_bits_resp(2'd0), .auto_out_r_bits_echo_tl_state_size(4'd3),
    .auto_out_r_bits_echo_tl_state_source(4'd6), .auto_out_r_bits_last(r_last_dn),
    .auto_in_r_valid(r_valid_up), .auto_in_r_ready(r_ready_up),
    .auto_in_r_bits_id(r_id_up), .auto_in_r_bits_data(r_data_up),
    .auto_in_r_bits_resp(r_resp_up), .auto_in_r_bits_echo_tl_state_size(r_esz_up),
    .auto_in_r_bits_echo_tl_state_source(r_esrc_up), .auto_in_r_bits_last(r_last_up),
    .drain_req(drain_req), .idle(idle), .underflow(underflow)
  );

  always #5 clock = ~clock;

  // One table row:
  //   - the upstream requests and downstream responses to drive this cycle.
  //   - the expected combinational AW/AR handshake.
  //   - the expected idle value after the edge.
  //   - optionally, one counter value after the edge
  //     (csel: 0 = none, 1 = wcnt, 2 = rcnt).
  typedef struct {
    logic       awv;   logic [3:0] awid;
    logic       bv;    logic [3:0] bid;
    logic       arv;   logic [3:0] arid;
    logic       rv;    logic [3:0] rid;  logic rlast;
    logic       drain;
    logic       e_awv; logic e_awr; logic e_arv; logic e_arr;
    logic       e_idle;
    int         csel;  int cid;  int cval;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(logic awv, int awid, logic bv, int bid,
                               logic arv, int arid, logic rv, int rid, logic rlast,
                               logic e_awv, logic e_awr, logic e_arv, logic e_arr,
                               logic e_idle, int csel, int cid, int cval);
    vec_t v;
    v.awv = awv; v.awid = 4'(awid); v.bv = bv; v.bid = 4'(bid);
    v.arv = arv; v.arid = 4'(arid); v.rv = rv; v.rid = 4'(rid); v.rlast = rlast;
    v.drain = 1'b0;
    v.e_awv = e_awv; v.e_awr = e_awr; v.e_arv = e_arv; v.e_arr = e_arr;
    v.e_idle = e_idle; v.csel = csel; v.cid = cid; v.cval = cval;
    return v;
  endfunction

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic clearInputs();
    in_aw_valid = 0; in_aw_id = 0; in_aw_addr = 0; out_aw_ready = 1;
    in_ar_valid = 0; in_ar_id = 0; in_ar_addr = 0; in_ar_len = 0; out_ar_ready = 1;
    in_w_valid = 0; in_w_data = 0; out_w_ready = 1;
    b_valid_dn = 0; b_id_dn = 0; b_resp_dn = 0; b_ready_up = 1;
    r_valid_dn = 0; r_id_dn = 0; r_data_dn = 0; r_last_dn = 0; r_ready_up = 1;
    drain_req = 0;
  endtask

  task automatic applyStimulus(input vec_t v);
    clearInputs();
    in_aw_valid = v.awv; in_aw_id = v.awid; in_aw_addr = $urandom;
    b_valid_dn  = v.bv;  b_id_dn  = v.bid;
    in_ar_valid = v.arv; in_ar_id = v.arid;
    r_valid_dn  = v.rv;  r_id_dn  = v.rid;  r_last_dn = v.rlast;
    drain_req   = v.drain;
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  int cnt_actual;

  initial begin
    clearInputs();
    reset = 1'b1;
    cycle(); cycle();
    reset = 1'b0;
    #2;
    checkOutput("reset idle", idle, 1);
    checkOutput("reset underflow", underflow, 0);
    checkOutput("reset aw_valid follows", out_aw_valid, 0);
    checkOutput("reset aw_ready follows", in_aw_ready, 1);

    // Rows: awv awid bv bid arv arid rv rid rlast |
    //       e_awv e_awr e_arv e_arr e_idle | csel cid cval
    // Five AWs on id 3: the 5th is held. One B frees the slot a cycle later.
    vecs.push_back(mkv(1,3, 0,0, 0,0, 0,0,0, 1,1,0,1, 0, 1,3,1));
    vecs.push_back(mkv(1,3, 0,0, 0,0, 0,0,0, 1,1,0,1, 0, 1,3,2));
    vecs.push_back(mkv(1,3, 0,0, 0,0, 0,0,0, 1,1,0,1, 0, 1,3,3));
    vecs.push_back(mkv(1,3, 0,0, 0,0, 0,0,0, 1,1,0,1, 0, 1,3,4));
    vecs.push_back(mkv(1,3, 0,0, 0,0, 0,0,0, 0,0,0,1, 0, 1,3,4));
    vecs.push_back(mkv(1,3, 1,3, 0,0, 0,0,0, 0,0,0,1, 0, 1,3,3));
    vecs.push_back(mkv(1,3, 0,0, 0,0, 0,0,0, 1,1,0,1, 0, 1,3,4));
    // id 7 flows while id 3 sits at its limit.
    vecs.push_back(mkv(1,7, 0,0, 0,0, 0,0,0, 1,1,0,1, 0, 1,7,1));
    vecs.push_back(mkv(1,3, 0,0, 0,0, 0,0,0, 0,0,0,1, 0, 1,3,4));
    vecs.push_back(mkv(1,7, 0,0, 0,0, 0,0,0, 1,1,0,1, 0, 1,7,2));
    // Retire everything; idle only after the final B.
    vecs.push_back(mkv(0,0, 1,3, 0,0, 0,0,0, 0,1,0,1, 0, 1,3,3));
    vecs.push_back(mkv(0,0, 1,3, 0,0, 0,0,0, 0,1,0,1, 0, 1,3,2));
    vecs.push_back(mkv(0,0, 1,3, 0,0, 0,0,0, 0,1,0,1, 0, 1,3,1));
    vecs.push_back(mkv(0,0, 1,3, 0,0, 0,0,0, 0,1,0,1, 0, 1,3,0));
    vecs.push_back(mkv(0,0, 1,7, 0,0, 0,0,0, 0,1,0,1, 0, 1,7,1));
    vecs.push_back(mkv(0,0, 1,7, 0,0, 0,0,0, 0,1,0,1, 1, 1,7,0));
    // Burst read on id 2: only the last R beat retires it.
    vecs.push_back(mkv(0,0, 0,0, 1,2, 0,0,0, 0,1,1,1, 0, 2,2,1));
    vecs.push_back(mkv(0,0, 0,0, 0,0, 1,2,0, 0,1,0,1, 0, 2,2,1));
    vecs.push_back(mkv(0,0, 0,0, 0,0, 1,2,0, 0,1,0,1, 0, 2,2,1));
    vecs.push_back(mkv(0,0, 0,0, 0,0, 1,2,0, 0,1,0,1, 0, 2,2,1));
    vecs.push_back(mkv(0,0, 0,0, 0,0, 1,2,1, 0,1,0,1, 1, 2,2,0));
    // Same-cycle AW and B: same ID cancels, different IDs both move.
    vecs.push_back(mkv(1,5, 0,0, 0,0, 0,0,0, 1,1,0,1, 0, 1,5,1));
    vecs.push_back(mkv(1,5, 0,0, 0,0, 0,0,0, 1,1,0,1, 0, 1,5,2));
    vecs.push_back(mkv(1,6, 0,0, 0,0, 0,0,0, 1,1,0,1, 0, 1,6,1));
    vecs.push_back(mkv(1,6, 0,0, 0,0, 0,0,0, 1,1,0,1, 0, 1,6,2));
    vecs.push_back(mkv(1,5, 1,5, 0,0, 0,0,0, 1,1,0,1, 0, 1,5,2));
    vecs.push_back(mkv(1,5, 1,6, 0,0, 0,0,0, 1,1,0,1, 0, 1,5,3));
    vecs.push_back(mkv(0,0, 0,0, 0,0, 0,0,0, 0,1,0,1, 0, 1,6,1));
    vecs.push_back(mkv(0,0, 1,5, 0,0, 0,0,0, 0,1,0,1, 0, 1,5,2));
    vecs.push_back(mkv(0,0, 1,5, 0,0, 0,0,0, 0,1,0,1, 0, 1,5,1));
    vecs.push_back(mkv(0,0, 1,5, 0,0, 0,0,0, 0,1,0,1, 0, 1,5,0));
    vecs.push_back(mkv(0,0, 1,6, 0,0, 0,0,0, 0,1,0,1, 1, 1,6,0));
    // AR limit on id 4, id 11 unaffected. R-last in the stalled cycle
    // only unblocks the following cycle.
    vecs.push_back(mkv(0,0, 0,0, 1,4, 0,0,0, 0,1,1,1, 0, 2,4,1));
    vecs.push_back(mkv(0,0, 0,0, 1,4, 0,0,0, 0,1,1,1, 0, 2,4,2));
    vecs.push_back(mkv(0,0, 0,0, 1,4, 0,0,0, 0,1,1,1, 0, 2,4,3));
    vecs.push_back(mkv(0,0, 0,0, 1,4, 0,0,0, 0,1,1,1, 0, 2,4,4));
    vecs.push_back(mkv(0,0, 0,0, 1,4, 0,0,0, 0,1,0,0, 0, 2,4,4));
    vecs.push_back(mkv(0,0, 0,0, 1,11, 0,0,0, 0,1,1,1, 0, 2,11,1));
    vecs.push_back(mkv(0,0, 0,0, 1,4, 1,4,1, 0,1,0,0, 0, 2,4,3));
    vecs.push_back(mkv(0,0, 0,0, 1,4, 0,0,0, 0,1,1,1, 0, 2,4,4));
    vecs.push_back(mkv(0,0, 0,0, 0,0, 1,4,1, 0,1,0,1, 0, 2,4,3));
    vecs.push_back(mkv(0,0, 0,0, 0,0, 1,4,1, 0,1,0,1, 0, 2,4,2));
    vecs.push_back(mkv(0,0, 0,0, 0,0, 1,4,1, 0,1,0,1, 0, 2,4,1));
    vecs.push_back(mkv(0,0, 0,0, 0,0, 1,4,1, 0,1,0,1, 0, 2,4,0));
    vecs.push_back(mkv(0,0, 0,0, 0,0, 1,11,1, 0,1,0,1, 1, 2,11,0));

    foreach (vecs[n]) begin
      applyStimulus(vecs[n]);
      #3;
      checkOutput($sformatf("v%0d out_aw_valid", n), out_aw_valid, vecs[n].e_awv);
      checkOutput($sformatf("v%0d in_aw_ready", n), in_aw_ready, vecs[n].e_awr);
      checkOutput($sformatf("v%0d out_ar_valid", n), out_ar_valid, vecs[n].e_arv);
      checkOutput($sformatf("v%0d in_ar_ready", n), in_ar_ready, vecs[n].e_arr);
      checkOutput($sformatf("v%0d aw addr", n), out_aw_addr, in_aw_addr);
      cycle();
      checkOutput($sformatf("v%0d idle", n), idle, vecs[n].e_idle);
      checkOutput($sformatf("v%0d underflow", n), underflow, 0);
      if (vecs[n].csel != 0) begin
        cnt_actual = (vecs[n].csel == 1) ? int'(dut.wcnt[vecs[n].cid]) : int'(dut.rcnt[vecs[n].cid]);
        checkOutput($sformatf("v%0d cnt id %0d", n, vecs[n].cid), cnt_actual, vecs[n].cval);
      end
    end

    // Drain with three writes open on id 1.
    // While drain_req is high:
    //   - AW/AR requests stay pending and nothing is admitted.
    //   - W beats still flow straight through.
    clearInputs();
    in_aw_valid = 1; in_aw_id = 1;
    cycle(); cycle(); cycle();
    in_aw_id = 2;
    in_ar_valid = 1; in_ar_id = 4;
    drain_req = 1;
    in_w_valid = 1; in_w_data = 64'hdead_beef_0123_4567; out_w_ready = 0;
    #2;
    checkOutput("drain aw_valid", out_aw_valid, 0);
    checkOutput("drain aw_ready", in_aw_ready, 0);
    checkOutput("drain ar_valid", out_ar_valid, 0);
    checkOutput("drain ar_ready", in_ar_ready, 0);
    checkOutput("drain w_valid", out_w_valid, 1);
    checkOutput("drain w_ready", in_w_ready, 0);
    checkOutput("drain w_data", out_w_data, 64'hdead_beef_0123_4567);
    b_valid_dn = 1; b_id_dn = 1; b_resp_dn = 2'd2;
    #1;
    checkOutput("b passthrough valid", b_valid_up, 1);
    checkOutput("b passthrough resp", b_resp_up, 2);
    checkOutput("b passthrough src", b_esrc_up, 5);
    cycle();
    checkOutput("drain idle after B1", idle, 0);
    cycle();
    checkOutput("drain idle after B2", idle, 0);
    cycle();
    checkOutput("drain idle after B3", idle, 1);
    checkOutput("drain no AW admitted", int'(dut.wcnt[2]), 0);
    checkOutput("drain no AR admitted", int'(dut.rcnt[4]), 0);
    b_valid_dn = 0;
    drain_req = 0;
    #1;
    checkOutput("undrain aw_valid same cycle", out_aw_valid, 1);
    checkOutput("undrain ar_valid same cycle", out_ar_valid, 1);

    // Underflow: a B on id 9 with nothing open.
    // underflow sets and stays set; the counter stays at zero.
    clearInputs();
    b_valid_dn = 1; b_id_dn = 9;
    cycle();
    checkOutput("underflow set", underflow, 1);
    checkOutput("underflow wcnt9", int'(dut.wcnt[9]), 0);
    b_valid_dn = 0;
    r_valid_dn = 1; r_id_dn = 8; r_last_dn = 0; r_data_dn = 64'h1234;
    #1;
    checkOutput("r passthrough data", r_data_up, 64'h1234);
    checkOutput("r passthrough last", r_last_up, 0);
    cycle();
    r_valid_dn = 0;
    cycle(); cycle();
    checkOutput("underflow sticky", underflow, 1);
    checkOutput("underflow idle", idle, 1);

    // Reset with transactions open clears every counter and the flag.
    in_aw_valid = 1; in_aw_id = 1;
    in_ar_valid = 1; in_ar_id = 5;
    cycle(); cycle();
    clearInputs();
    checkOutput("pre-reset wcnt1", int'(dut.wcnt[1]), 2);
    checkOutput("pre-reset idle", idle, 0);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    checkOutput("post-reset wcnt1", int'(dut.wcnt[1]), 0);
    checkOutput("post-reset rcnt5", int'(dut.rcnt[5]), 0);
    checkOutput("post-reset idle", idle, 1);
    checkOutput("post-reset underflow", underflow, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
